// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcode encodings, default widths and the
// reservation-station entry layout.
package tomasulo_pkg;

    localparam int unsigned RS_DEPTH  = 4;
    localparam int unsigned RS_DATA_W = 16;
    localparam int unsigned RS_TAG_W  = 3;
    localparam int unsigned RS_FUNC_W = 4;

    typedef enum logic [RS_FUNC_W-1:0] {
        FUNC_ADD = 4'b0000,
        FUNC_SUB = 4'b0001,
        FUNC_MUL = 4'b0010,
        FUNC_DIV = 4'b0011,
        FUNC_LD  = 4'b0100,
        FUNC_ST  = 4'b0101,
        FUNC_BEQ = 4'b0110,
        FUNC_BNE = 4'b0111
    } func_e;

    typedef struct packed {
        logic                 rdy;
        logic [RS_DATA_W-1:0] val;
        logic [RS_TAG_W-1:0]  tag;
    } rs_src_t;

    typedef struct packed {
        logic                 busy;
        logic [RS_FUNC_W-1:0] func;
        logic [RS_TAG_W-1:0]  rob;
        rs_src_t [1:0]        src;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the reservation station: tracks relative entry age and
// grants the oldest candidate (one-hot).
module rs_age_select
    import tomasulo_pkg::*;
#(
    parameter int unsigned DEPTH = RS_DEPTH
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc_sel,
    input  logic [DEPTH-1:0] free_sel,
    input  logic [DEPTH-1:0] cand,
    output logic [DEPTH-1:0] grant,
    output logic             any_grant
);

    // age_q[i][j] = 1 means entry i is older than entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (alloc_sel[k]) begin
                age_d[k] = '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (i != k) begin
                        age_d[i][k] = 1'b1;
                    end
                end
            end
        end
        for (int unsigned f = 0; f < DEPTH; f++) begin
            if (free_sel[f]) begin
                age_d[f] = '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    age_d[i][f] = 1'b0;
                end
            end
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // A candidate wins when no other candidate is older than it
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic older;
            older = 1'b0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                older = older | (cand[j] & age_q[j][i]);
            end
            grant[i] = cand[i] & ~older;
        end
    end

    assign any_grant = |grant;

endmodule

// File: rtl/rs_tagged_station.sv
// Reservation station with in-entry operand capture, CDB wakeup,
// oldest-ready issue over valid/ready, and flush.
module rs_tagged_station
    import tomasulo_pkg::*;
#(
    parameter int unsigned DEPTH  = RS_DEPTH,
    parameter int unsigned DATA_W = RS_DATA_W,
    parameter int unsigned TAG_W  = RS_TAG_W,
    parameter int unsigned FUNC_W = RS_FUNC_W,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [TAG_W-1:0]  alloc_rob,
    input  logic              alloc_rs1_rdy,
    input  logic [DATA_W-1:0] alloc_rs1_val,
    input  logic [TAG_W-1:0]  alloc_rs1_tag,
    input  logic              alloc_rs2_rdy,
    input  logic [DATA_W-1:0] alloc_rs2_val,
    input  logic [TAG_W-1:0]  alloc_rs2_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [FUNC_W-1:0] issue_func,
    output logic [DATA_W-1:0] issue_rs1,
    output logic [DATA_W-1:0] issue_rs2,
    output logic [TAG_W-1:0]  issue_rob,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy
);

    // Same layout as rs_entry_t, sized by this instance's parameters
    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  tag;
    } src_t;

    typedef struct packed {
        logic              busy;
        logic [FUNC_W-1:0] func;
        logic [TAG_W-1:0]  rob;
        src_t [1:0]        src;
    } entry_t;

    entry_t           ents_q [DEPTH];
    entry_t           ents_d [DEPTH];
    logic [OCC_W-1:0] occ_q;

    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] grant;
    logic             any_grant;
    logic             alloc_fire;
    logic             issue_fire;

    function automatic src_t wake(input src_t s, input logic cv,
                                  input logic [TAG_W-1:0] ct,
                                  input logic [DATA_W-1:0] cd);
        src_t r;
        r = s;
        if (!s.rdy && cv && (s.tag == ct)) begin
            r.rdy = 1'b1;
            r.val = cd;
        end
        return r;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_vec[i] = ents_q[i].busy;
            cand[i]     = ents_q[i].busy & ents_q[i].src[0].rdy & ents_q[i].src[1].rdy;
        end
    end

    // Lowest-index free slot
    always_comb begin
        logic found;
        alloc_sel = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!busy_vec[i] && !found) begin
                alloc_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign alloc_ready = ~&busy_vec;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign issue_valid = any_grant;
    assign issue_fire  = issue_valid & issue_ready;

    rs_age_select #(.DEPTH(DEPTH)) u_age (
        .clk1      (clk1),
        .rst       (rst),
        .flush     (flush),
        .alloc_sel (alloc_fire ? alloc_sel : '0),
        .free_sel  (issue_fire ? grant : '0),
        .cand      (cand),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_comb begin
        src_t a1;
        src_t a2;
        a1 = '{rdy: alloc_rs1_rdy, val: alloc_rs1_val, tag: alloc_rs1_tag};
        a2 = '{rdy: alloc_rs2_rdy, val: alloc_rs2_val, tag: alloc_rs2_tag};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ents_d[i] = ents_q[i];
            if (ents_q[i].busy) begin
                ents_d[i].src[0] = wake(ents_q[i].src[0], cdb_valid, cdb_tag, cdb_data);
                ents_d[i].src[1] = wake(ents_q[i].src[1], cdb_valid, cdb_tag, cdb_data);
            end
            if (issue_fire && grant[i]) begin
                ents_d[i].busy = 1'b0;
            end
            if (alloc_fire && alloc_sel[i]) begin
                ents_d[i].busy   = 1'b1;
                ents_d[i].func   = alloc_func;
                ents_d[i].rob    = alloc_rob;
                ents_d[i].src[0] = wake(a1, cdb_valid, cdb_tag, cdb_data);
                ents_d[i].src[1] = wake(a2, cdb_valid, cdb_tag, cdb_data);
            end
            if (flush) begin
                ents_d[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ents_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ents_q[i] <= ents_d[i];
            end
            if (flush) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_q + OCC_W'(alloc_fire) - OCC_W'(issue_fire);
            end
        end
    end

    assign occupancy = occ_q;

    // Issue payload: AND-OR mux on the one-hot grant, zero when idle
    always_comb begin
        issue_func = '0;
        issue_rs1  = '0;
        issue_rs2  = '0;
        issue_rob  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_func = issue_func | ents_q[i].func;
                issue_rs1  = issue_rs1 | ents_q[i].src[0].val;
                issue_rs2  = issue_rs2 | ents_q[i].src[1].val;
                issue_rob  = issue_rob | ents_q[i].rob;
            end
        end
    end

endmodule

// File: tb/tb_rs_tagged_station.sv
// Directed bench for rs_tagged_station: per-cycle vector table plus
// hand-written stall/flush and async-reset sequences.
module tb_rs_tagged_station;

    logic        clk1;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_func;
    logic [2:0]  alloc_rob;
    logic        alloc_rs1_rdy;
    logic [15:0] alloc_rs1_val;
    logic [2:0]  alloc_rs1_tag;
    logic        alloc_rs2_rdy;
    logic [15:0] alloc_rs2_val;
    logic [2:0]  alloc_rs2_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_func;
    logic [15:0] issue_rs1;
    logic [15:0] issue_rs2;
    logic [2:0]  issue_rob;
    logic        flush;
    logic [2:0]  occupancy;

    rs_tagged_station dut (
        .clk1          (clk1),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_func    (alloc_func),
        .alloc_rob     (alloc_rob),
        .alloc_rs1_rdy (alloc_rs1_rdy),
        .alloc_rs1_val (alloc_rs1_val),
        .alloc_rs1_tag (alloc_rs1_tag),
        .alloc_rs2_rdy (alloc_rs2_rdy),
        .alloc_rs2_val (alloc_rs2_val),
        .alloc_rs2_tag (alloc_rs2_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_func    (issue_func),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rob     (issue_rob),
        .flush         (flush),
        .occupancy     (occupancy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        int av; int func; int rob;
        int r1r; int r1v; int r1t;
        int r2r; int r2v; int r2t;
        int cv; int ct; int cd;
        int ir; int fl;
        int e_ar; int e_iv; int e_func; int e_rs1; int e_rs2; int e_rob; int e_occ;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_func = 0; alloc_rob = 0;
        alloc_rs1_rdy = 0; alloc_rs1_val = 0; alloc_rs1_tag = 0;
        alloc_rs2_rdy = 0; alloc_rs2_val = 0; alloc_rs2_tag = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        issue_ready = 0; flush = 0;
    endtask

    task automatic apply(input vec_t v);
        alloc_valid   = v.av[0];
        alloc_func    = 4'(v.func);
        alloc_rob     = 3'(v.rob);
        alloc_rs1_rdy = v.r1r[0];
        alloc_rs1_val = 16'(v.r1v);
        alloc_rs1_tag = 3'(v.r1t);
        alloc_rs2_rdy = v.r2r[0];
        alloc_rs2_val = 16'(v.r2v);
        alloc_rs2_tag = 3'(v.r2t);
        cdb_valid     = v.cv[0];
        cdb_tag       = 3'(v.ct);
        cdb_data      = 16'(v.cd);
        issue_ready   = v.ir[0];
        flush         = v.fl[0];
    endtask

    initial begin
        // Row fields: av func rob | rs1 rdy val tag | rs2 rdy val tag | cdb v tag data | ir fl
        //             | expected ar iv func rs1 rs2 rob occ (after the edge)
        vecs[0]  = '{1,0,2, 1,5,0, 1,7,0, 0,0,0, 1,0,  1,1,0,5,7,2,1};
        vecs[1]  = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,0,0,0,0,0,0};
        vecs[2]  = '{1,2,1, 0,0,4, 1,3,0, 0,0,0, 1,0,  1,0,0,0,0,0,1};
        vecs[3]  = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,0,0,0,0,0,1};
        vecs[4]  = '{0,0,0, 0,0,0, 0,0,0, 1,4,9, 1,0,  1,1,2,9,3,1,1};
        vecs[5]  = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,0,0,0,0,0,0};
        vecs[6]  = '{1,1,5, 1,1,0, 0,0,6, 1,6,'hAA, 1,0,  1,1,1,1,'hAA,5,1};
        vecs[7]  = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,0,0,0,0,0,0};
        vecs[8]  = '{1,0,6, 1,10,0, 1,11,0, 0,0,0, 0,0,  1,1,0,10,11,6,1};
        vecs[9]  = '{1,6,0, 0,0,7, 0,0,7, 0,0,0, 1,0,  1,0,0,0,0,0,1};
        vecs[10] = '{1,4,1, 0,0,7, 0,0,7, 0,0,0, 0,0,  1,0,0,0,0,0,2};
        vecs[11] = '{1,5,2, 0,0,7, 1,'h22,0, 0,0,0, 0,0,  1,0,0,0,0,0,3};
        vecs[12] = '{1,7,3, 1,'h33,0, 0,0,7, 0,0,0, 0,0,  0,0,0,0,0,0,4};
        vecs[13] = '{1,3,5, 1,1,0, 1,1,0, 0,0,0, 0,0,  0,0,0,0,0,0,4};
        vecs[14] = '{0,0,0, 0,0,0, 0,0,0, 1,7,'h77, 0,0,  0,1,6,'h77,'h77,0,4};
        vecs[15] = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,1,4,'h77,'h77,1,3};
        vecs[16] = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,1,5,'h77,'h22,2,2};
        vecs[17] = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,1,7,'h33,'h77,3,1};
        vecs[18] = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,0,0,0,0,0,0};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk1);
        chk("reset alloc_ready", int'(alloc_ready), 1);
        chk("reset issue_valid", int'(issue_valid), 0);
        chk("reset occupancy", int'(occupancy), 0);
        chk("reset issue_func", int'(issue_func), 0);
        chk("reset issue_rs1", int'(issue_rs1), 0);
        chk("reset issue_rs2", int'(issue_rs2), 0);
        chk("reset issue_rob", int'(issue_rob), 0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            step();
            chk($sformatf("row%0d alloc_ready", i), int'(alloc_ready), vecs[i].e_ar);
            chk($sformatf("row%0d issue_valid", i), int'(issue_valid), vecs[i].e_iv);
            chk($sformatf("row%0d occupancy", i), int'(occupancy), vecs[i].e_occ);
            if (vecs[i].e_iv != 0) begin
                chk($sformatf("row%0d issue_func", i), int'(issue_func), vecs[i].e_func);
                chk($sformatf("row%0d issue_rs1", i), int'(issue_rs1), vecs[i].e_rs1);
                chk($sformatf("row%0d issue_rs2", i), int'(issue_rs2), vecs[i].e_rs2);
                chk($sformatf("row%0d issue_rob", i), int'(issue_rob), vecs[i].e_rob);
            end
        end
        idle_inputs();

        // Stall: one ready entry held under backpressure
        alloc_valid = 1; alloc_func = 4'b0000; alloc_rob = 3'd4;
        alloc_rs1_rdy = 1; alloc_rs1_val = 16'h1234;
        alloc_rs2_rdy = 1; alloc_rs2_val = 16'h5678;
        step();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d issue_valid", c), int'(issue_valid), 1);
            chk($sformatf("stall%0d issue_rs1", c), int'(issue_rs1), 'h1234);
            chk($sformatf("stall%0d issue_rs2", c), int'(issue_rs2), 'h5678);
            chk($sformatf("stall%0d issue_rob", c), int'(issue_rob), 4);
            step();
        end

        // Flush overrides a same-cycle alloc and issue
        flush = 1; issue_ready = 1;
        alloc_valid = 1; alloc_func = 4'b0001; alloc_rob = 3'd7;
        alloc_rs1_rdy = 1; alloc_rs1_val = 16'h0BAD;
        alloc_rs2_rdy = 1; alloc_rs2_val = 16'h0BAD;
        step();
        idle_inputs();
        chk("flush occupancy", int'(occupancy), 0);
        chk("flush issue_valid", int'(issue_valid), 0);
        chk("flush alloc_ready", int'(alloc_ready), 1);
        step();
        chk("post-flush issue_valid", int'(issue_valid), 0);
        chk("post-flush occupancy", int'(occupancy), 0);

        // Async reset with three waiting entries
        for (int k = 0; k < 3; k++) begin
            alloc_valid = 1; alloc_func = 4'b0010; alloc_rob = 3'(k);
            alloc_rs1_rdy = 0; alloc_rs1_tag = 3'd5;
            alloc_rs2_rdy = 1; alloc_rs2_val = 16'h0001;
            step();
        end
        idle_inputs();
        chk("pre-rst occupancy", int'(occupancy), 3);
        cdb_valid = 1; cdb_tag = 3'd5; cdb_data = 16'h0055;
        step();
        chk("pre-rst issue_valid", int'(issue_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst alloc_ready", int'(alloc_ready), 1);
        chk("async rst issue_valid", int'(issue_valid), 0);
        chk("async rst occupancy", int'(occupancy), 0);
        chk("async rst issue_rs1", int'(issue_rs1), 0);
        #1 rst = 1'b0;
        idle_inputs();
        step();
        chk("post-rst occupancy", int'(occupancy), 0);
        chk("post-rst issue_valid", int'(issue_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rs_tagged_station.md
Name: rs_tagged_station

Overview:
- Parametrised reservation station for the Tomasulo core: holds DEPTH in-flight ops with value/tag operand capture.
- Snoops the common data bus (CDB) to wake waiting operands and issues the oldest fully-ready entry to one functional unit over a valid/ready handshake.
- One instance per functional-unit class (add/branch/mem, mul/div). Sits between the decode/ROB-allocate stage and exec.
- Adds what the single-shot station lacks: operand values held in-entry, CDB wakeup, age-ordered select, backpressure, flush.

Parameters:
DEPTH, 4, number of station entries (2..16)
DATA_W, 16, operand/result data width
TAG_W, 3, ROB index width (producer tag)
FUNC_W, 4, opcode width

Ports:
clk1  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
alloc_valid  in  1  decode presents an op
alloc_ready  out  1  at least one free entry
alloc_func  in  FUNC_W  opcode
alloc_rob  in  TAG_W  destination ROB index
alloc_rs1_rdy  in  1  1 = rs1 value valid, 0 = waiting on tag
alloc_rs1_val  in  DATA_W  rs1 value (used when rdy=1)
alloc_rs1_tag  in  TAG_W  rs1 producer ROB index (used when rdy=0)
alloc_rs2_rdy / alloc_rs2_val / alloc_rs2_tag  in  1/DATA_W/TAG_W  same for rs2
cdb_valid  in  1  result broadcast this cycle
cdb_tag  in  TAG_W  producing ROB index
cdb_data  in  DATA_W  result value
issue_valid  out  1  an entry is selected for exec
issue_ready  in  1  exec unit accepts
issue_func  out  FUNC_W  selected opcode
issue_rs1  out  DATA_W  selected rs1 value
issue_rs2  out  DATA_W  selected rs2 value
issue_rob  out  TAG_W  selected ROB index
flush  in  1  squash all entries (branch mispredict)
occupancy  out  $clog2(DEPTH+1)  busy-entry count

Behaviour:
- Entry state: busy, func, rob, {rdy,val,tag} per source. Reset: all busy=0, age matrix cleared, occupancy=0, alloc_ready=1, issue_valid=0, issue data outputs 0.
- Allocate: on alloc_valid && alloc_ready at the clock edge, write the lowest-index free entry and set busy=1. The new entry becomes younger than every busy entry.
- alloc_ready = any entry not busy, computed from current state only. An entry freed by issue in the same cycle is not reusable until the next cycle.
- Allocation bypass: a source with rdy=0 whose tag equals cdb_tag while cdb_valid in the allocation cycle is stored as rdy=1, val=cdb_data.
- Wakeup: each cycle, every busy entry with a source rdy=0 and tag==cdb_tag && cdb_valid captures cdb_data and sets rdy=1. Both sources may wake in the same cycle.
- Select is combinational from registered state. Candidate = busy && rs1.rdy && rs2.rdy. issue_valid = any candidate; the oldest candidate drives the issue_* outputs.
- An entry woken this cycle becomes a candidate next cycle, giving at least 1 cycle from CDB to issue.
- Issue handshake: on issue_valid && issue_ready the selected entry's busy is cleared at that edge.
- Stall: while issue_ready=0, issue outputs stay stable unless an older entry becomes a candidate. That is allowed: the handshake is not sticky, and exec samples only on acceptance.
- Simultaneous alloc + issue + wakeup in one cycle are all legal and independent. occupancy += alloc_fire - issue_fire.
- flush: synchronous. All busy=0 and occupancy=0 at the edge, overriding a same-cycle alloc and issue; the issue handshake that cycle is discarded.
- rst mid-operation clears everything asynchronously. Outputs follow the reset values immediately.
- alloc_valid while alloc_ready=0 is ignored (no write, no error).
- Widths: no arithmetic on data. Tags are compared with full TAG_W equality. ROB index wrap is handled by the ROB, not here.

Decomposition:
- Package tomasulo_pkg holds:
  - func encodings: ADD=0000, SUB=0001, MUL=0010, DIV=0011, LD=0100, ST=0101, BEQ=0110, BNE=0111;
  - the rs_entry_t struct (busy, func, rob, src[2] of {rdy, val, tag});
  - default widths.
- Sub-module rs_age_select holds the DEPTH×DEPTH age matrix. It is updated on alloc and free, takes the candidate vector, and returns a one-hot grant plus any-grant.

Test Plan:
- Reset, then alloc ADD rob=2, rs1 rdy val=5, rs2 rdy val=7, issue_ready=1 → next cycle issue_valid=1, func=0000, rs1=5, rs2=7, rob=2; entry freed after the accepting edge, occupancy back to 0.
- Alloc MUL rob=1, rs1 waiting tag=4, rs2 rdy=3; two cycles later cdb_valid, tag=4, data=9 → issue_valid the cycle after the broadcast with rs1=9, rs2=3.
- Alloc with rs2 tag=6 in the same cycle as cdb tag=6, data=0x00AA → entry stored ready; issues the next cycle with rs2=0x00AA.
- Fill DEPTH=4 entries, all waiting → alloc_ready=0, a 5th alloc is ignored, occupancy=4. Wake all with one tag → issue order equals allocation order (rob 0,1,2,3) regardless of slot index.
- issue_ready=0 for 5 cycles with one ready entry → issue_valid=1 held, outputs stable. Then assert flush with alloc_valid=1 → occupancy=0, issue_valid=0 next cycle, no entry written.
- Assert rst asynchronously mid-sequence with 3 busy entries → alloc_ready=1, issue_valid=0, occupancy=0 before the next clock edge.
